// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stage indices,
// default geometry and the output-selection mode.
package pipe_ctrl_pkg;

    localparam int STAGES_DEF = 5;

    localparam int STG_PC  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int MD_STAGE_DEF = STG_EX;

    // Which rule is driving stage_en/stage_clr in the current cycle.
    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_STALL = 2'd1,
        MODE_FLUSH = 2'd2,
        MODE_RESET = 2'd3
    } ctrl_mode_e;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div latency countdown: loads the op latency on an accepted start and
// counts down to zero; a start while still counting is rejected and flagged.
module md_busy_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             md_start,
    input  logic [CNT_W-1:0] md_lat,
    output logic             md_busy,
    output logic             md_err
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (md_start && (r_cnt == '0)) begin
            r_cnt <= md_lat;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign md_busy = (r_cnt != '0);
    assign md_err  = md_start && md_busy;

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline hazard controller: turns per-stage stall/flush requests and the
// mult/div busy state into register load enables, bubble inserts and counters.
module stall_flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES   = STAGES_DEF,
    parameter int MD_STAGE = MD_STAGE_DEF,
    parameter int MD_CNT_W = 4,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [STAGES-1:0]   stall_req,
    input  logic [STAGES-1:0]   flush_req,
    input  logic                md_start,
    input  logic [MD_CNT_W-1:0] md_lat,
    input  logic                md_use,
    output logic [STAGES-1:0]   stage_en,
    output logic [STAGES-1:0]   stage_clr,
    output logic                flush_ack,
    output logic                md_busy,
    output logic [PERF_W-1:0]   stall_cycles,
    output logic [PERF_W-1:0]   flush_count,
    output logic                err_sticky
);

    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic              w_md_busy;
    logic              w_md_err;
    logic [STAGES-1:0] w_eff_stall;
    logic              w_s_vld;
    logic [IDX_W-1:0]  w_s;
    logic              w_f_vld;
    logic [IDX_W-1:0]  w_f;
    ctrl_mode_e        w_mode;

    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_count;
    logic              r_err_sticky;

    md_busy_counter #(
        .CNT_W (MD_CNT_W)
    ) u_md_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start),
        .md_lat   (md_lat),
        .md_busy  (w_md_busy),
        .md_err   (w_md_err)
    );

    // Highest set index wins: the oldest stalling stage and the oldest redirect.
    // flush_req[0] has nothing younger to kill, so it never takes part.
    always_comb begin
        w_eff_stall = stall_req;
        if (md_use && w_md_busy) begin
            w_eff_stall[MD_STAGE] = 1'b1;
        end
        w_s_vld = 1'b0;
        w_s     = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (w_eff_stall[i]) begin
                w_s_vld = 1'b1;
                w_s     = IDX_W'(i);
            end
        end
        w_f_vld = 1'b0;
        w_f     = '0;
        for (int i = 1; i < STAGES; i++) begin
            if (flush_req[i]) begin
                w_f_vld = 1'b1;
                w_f     = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (!rst_n) begin
            w_mode = MODE_RESET;
        end else if (w_f_vld && (!w_s_vld || (w_s < w_f))) begin
            w_mode = MODE_FLUSH;
        end else if (w_s_vld) begin
            w_mode = MODE_STALL;
        end else begin
            w_mode = MODE_RUN;
        end
    end

    always_comb begin
        stage_en  = '1;
        stage_clr = '0;
        flush_ack = 1'b0;
        case (w_mode)
            MODE_RESET: begin
                stage_en  = '0;
                stage_clr = '1;
            end
            MODE_FLUSH: begin
                flush_ack = 1'b1;
                for (int j = 1; j < STAGES; j++) begin
                    if (j <= int'(w_f)) begin
                        stage_clr[j] = 1'b1;
                    end
                end
            end
            MODE_STALL: begin
                // Freeze everything up to the stall point, bubble the stage after it.
                for (int j = 0; j < STAGES; j++) begin
                    if (j <= int'(w_s)) begin
                        stage_en[j] = 1'b0;
                    end
                    if (j == int'(w_s) + 1) begin
                        stage_clr[j] = 1'b1;
                    end
                end
            end
            default: begin
                stage_en  = '1;
                stage_clr = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
            r_err_sticky   <= 1'b0;
        end else begin
            if (!stage_en[0] && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
            if (flush_ack && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + PERF_W'(1);
            end
            if (w_md_err || flush_req[0]) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign md_busy      = w_md_busy;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
    assign err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed bench for stall_flush_ctrl (STAGES=5, MD_STAGE=2, PERF_W=4):
// a driver pushes hand-computed expectations, a negedge monitor checks them.
module tb_stall_flush_ctrl;

    typedef struct packed {
        logic [15:0] id;
        logic [4:0]  en;
        logic [4:0]  clr;
        logic        ack;
        logic        busy;
        logic        err;
        logic [3:0]  sc;
        logic [3:0]  fc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] stall_req;
    logic [4:0] flush_req;
    logic       md_start;
    logic [3:0] md_lat;
    logic       md_use;
    logic [4:0] stage_en;
    logic [4:0] stage_clr;
    logic       flush_ack;
    logic       md_busy;
    logic [3:0] stall_cycles;
    logic [3:0] flush_count;
    logic       err_sticky;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   vec_id = 0;

    stall_flush_ctrl #(
        .STAGES   (5),
        .MD_STAGE (2),
        .MD_CNT_W (4),
        .PERF_W   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_req    (stall_req),
        .flush_req    (flush_req),
        .md_start     (md_start),
        .md_lat       (md_lat),
        .md_use       (md_use),
        .stage_en     (stage_en),
        .stage_clr    (stage_clr),
        .flush_ack    (flush_ack),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .err_sticky   (err_sticky)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_n     = 1'b0;
        stall_req = '0;
        flush_req = '0;
        md_start  = 1'b0;
        md_lat    = '0;
        md_use    = 1'b0;
    end

    // Driver: one vector per cycle, inputs applied 1 time unit after the edge
    task automatic vec(input logic rst, input logic [4:0] st, input logic [4:0] fl,
                       input logic mds, input logic [3:0] lat, input logic use_i,
                       input logic [4:0] e_en, input logic [4:0] e_clr, input logic e_ack,
                       input logic e_busy, input logic e_err,
                       input logic [3:0] e_sc, input logic [3:0] e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        stall_req = st;
        flush_req = fl;
        md_start  = mds;
        md_lat    = lat;
        md_use    = use_i;
        e.id   = 16'(vec_id);
        e.en   = e_en;
        e.clr  = e_clr;
        e.ack  = e_ack;
        e.busy = e_busy;
        e.err  = e_err;
        e.sc   = e_sc;
        e.fc   = e_fc;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic idle(input logic [4:0] e_en, input logic e_busy, input logic e_err,
                        input logic [3:0] e_sc, input logic [3:0] e_fc);
        vec(1'b1, 5'b0, 5'b0, 1'b0, 4'd0, 1'b0, e_en, 5'b0, 1'b0, e_busy, e_err, e_sc, e_fc);
    endtask

    task automatic do_reset();
        repeat (2) vec(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b0,
                       5'b00000, 5'b11111, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    // Scoreboard / monitor
    task automatic chk(input string nm, input int id, input logic [7:0] got, input logic [7:0] exp);
        if (got !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got %h expected %h", id, nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            chk("stage_en",     int'(e.id), 8'(stage_en),     8'(e.en));
            chk("stage_clr",    int'(e.id), 8'(stage_clr),    8'(e.clr));
            chk("flush_ack",    int'(e.id), 8'(flush_ack),    8'(e.ack));
            chk("md_busy",      int'(e.id), 8'(md_busy),      8'(e.busy));
            chk("err_sticky",   int'(e.id), 8'(err_sticky),   8'(e.err));
            chk("stall_cycles", int'(e.id), 8'(stall_cycles), 8'(e.sc));
            chk("flush_count",  int'(e.id), 8'(flush_count),  8'(e.fc));
        end
    end

    initial begin
        int k;
        // Stall and flush priority
        do_reset();
        vec(1, 5'b00100, 5'b00000, 0, 0, 0, 5'b11000, 5'b01000, 0, 0, 0, 4'd0, 4'd0);
        idle(5'b11111, 0, 0, 4'd1, 4'd0);
        vec(1, 5'b00100, 5'b01000, 0, 0, 0, 5'b11111, 5'b01110, 1, 0, 0, 4'd1, 4'd0);
        vec(1, 5'b10000, 5'b01000, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 4'd1, 4'd1);
        idle(5'b11111, 0, 0, 4'd2, 4'd1);
        vec(1, 5'b00000, 5'b10000, 0, 0, 0, 5'b11111, 5'b11110, 1, 0, 0, 4'd2, 4'd1);
        vec(1, 5'b00010, 5'b00010, 0, 0, 0, 5'b11100, 5'b00100, 0, 0, 0, 4'd2, 4'd2);
        vec(1, 5'b00000, 5'b00010, 0, 0, 0, 5'b11111, 5'b00010, 1, 0, 0, 4'd3, 4'd2);
        idle(5'b11111, 0, 0, 4'd3, 4'd3);

        // Mult/div interlock, then zero-latency op
        do_reset();
        vec(1, 5'b0, 5'b0, 1, 4'd3, 0, 5'b11111, 5'b00000, 0, 0, 0, 4'd0, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 1, 5'b11000, 5'b01000, 0, 1, 0, 4'd0, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 1, 5'b11000, 5'b01000, 0, 1, 0, 4'd1, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 1, 5'b11000, 5'b01000, 0, 1, 0, 4'd2, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 1, 5'b11111, 5'b00000, 0, 0, 0, 4'd3, 4'd0);
        vec(1, 5'b0, 5'b0, 1, 4'd0, 1, 5'b11111, 5'b00000, 0, 0, 0, 4'd3, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 1, 5'b11111, 5'b00000, 0, 0, 0, 4'd3, 4'd0);

        // Start while busy is rejected and recorded
        do_reset();
        vec(1, 5'b0, 5'b0, 1, 4'd3, 0, 5'b11111, 5'b0, 0, 0, 0, 4'd0, 4'd0);
        vec(1, 5'b0, 5'b0, 1, 4'd7, 0, 5'b11111, 5'b0, 0, 1, 0, 4'd0, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 0, 5'b11111, 5'b0, 0, 1, 1, 4'd0, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 0, 5'b11111, 5'b0, 0, 1, 1, 4'd0, 4'd0);
        idle(5'b11111, 0, 1, 4'd0, 4'd0);

        // flush_req[0] is an error and otherwise ignored
        do_reset();
        vec(1, 5'b0, 5'b00001, 0, 0, 0, 5'b11111, 5'b0, 0, 0, 0, 4'd0, 4'd0);
        idle(5'b11111, 0, 1, 4'd0, 4'd0);

        // Reset in the middle of a long op
        do_reset();
        vec(1, 5'b0, 5'b0, 1, 4'd5, 0, 5'b11111, 5'b0, 0, 0, 0, 4'd0, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 1, 5'b11000, 5'b01000, 0, 1, 0, 4'd0, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 1, 5'b11000, 5'b01000, 0, 1, 0, 4'd1, 4'd0);
        vec(0, 5'b0, 5'b0, 0, 4'd0, 1, 5'b00000, 5'b11111, 0, 0, 0, 4'd0, 4'd0);
        vec(0, 5'b0, 5'b0, 0, 4'd0, 1, 5'b00000, 5'b11111, 0, 0, 0, 4'd0, 4'd0);
        vec(1, 5'b0, 5'b0, 0, 4'd0, 1, 5'b11111, 5'b00000, 0, 0, 0, 4'd0, 4'd0);

        // Stall counter saturation
        do_reset();
        for (int i = 0; i < 18; i++) begin
            k = (i > 15) ? 15 : i;
            vec(1, 5'b00001, 5'b0, 0, 0, 0, 5'b11110, 5'b00010, 0, 0, 0, 4'(k), 4'd0);
        end
        idle(5'b11111, 0, 0, 4'd15, 4'd0);

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
